// File: rtl/pf_issue_queue.sv
// Prefetch issue queue: circular FIFO between the prefetcher and memory, with a two-state issue FSM.
// Optional PF_DEDUP_EN drops requests whose address already sits in the queue.
module pf_issue_queue #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       pf_v,
   input  logic [15:0]                pf_addr,
   output logic                       mem_v,
   output logic [15:0]                mem_addr,
   input  logic                       mem_ready,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic [15:0]                drop_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [15:0]     store_r [DEPTH];
   logic [PW-1:0]   head_r;
   logic [PW-1:0]   tail_r;
   logic [PW-1:0]   head_inc_s;
   logic [CW-1:0]   count_r;
   logic [CW-1:0]   count_nxt_s;
   logic            full_r;
   logic [15:0]     drop_cnt_r;
   logic [15:0]     mem_addr_r;
   logic [15:0]     mem_addr_nxt_s;
   logic            dup_s;
   logic            drop_s;
   logic            push_s;
   logic            pop_s;
   logic            last_s;

`ifdef PF_DEDUP_EN
   // Match incoming address against every occupied slot; a slot being popped this cycle still counts.
   always_comb begin
      dup_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (({1'b0, PW'(PW'(i) - head_r)} < count_r) && (store_r[i] == pf_addr)) begin
            dup_s = 1'b1;
         end else begin
            dup_s = dup_s;
         end
      end
   end
`else
   assign dup_s = 1'b0;
`endif

   // Push/pop decode, next count, next issue address and next FSM state.
   always_comb begin
      drop_s      = pf_v & (full_r | dup_s);
      push_s      = pf_v & ~drop_s;
      pop_s       = (state_r == ST_ISSUE) & mem_ready;
      last_s      = (count_r == {{PW{1'b0}}, 1'b1});
      head_inc_s  = head_r + PW'(1'b1);
      count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);

      // Issue address is kept registered, so it is fetched one step ahead of the head pointer.
      if (push_s && ((state_r == ST_EMPTY) || (pop_s && last_s))) begin
         mem_addr_nxt_s = pf_addr;
      end else if (pop_s) begin
         mem_addr_nxt_s = store_r[head_inc_s];
      end else begin
         mem_addr_nxt_s = mem_addr_r;
      end

      case (state_r)
         ST_EMPTY: begin
            if (push_s) begin
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_ISSUE: begin
            if (pop_s && last_s && !push_s) begin
               state_nxt_s = ST_EMPTY;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         default: state_nxt_s = ST_EMPTY;
      endcase
   end

   // Control state: pointers, occupancy, FSM and saturating drop counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_r     <= '0;
         tail_r     <= '0;
         count_r    <= '0;
         full_r     <= 1'b0;
         state_r    <= ST_EMPTY;
         drop_cnt_r <= 16'h0000;
      end else begin
         if (push_s) begin
            tail_r <= tail_r + PW'(1'b1);
         end
         if (pop_s) begin
            head_r <= head_inc_s;
         end
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == CW'(DEPTH));
         state_r <= state_nxt_s;
         if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
         end
      end
   end

   // Entry storage and issue address carry no reset; their contents are meaningless while empty.
   always_ff @(posedge clk) begin
      if (!rst && push_s) begin
         store_r[tail_r] <= pf_addr;
      end
      if (!rst) begin
         mem_addr_r <= mem_addr_nxt_s;
      end
   end

   assign mem_v    = (state_r == ST_ISSUE);
   assign mem_addr = mem_addr_r;
   assign full     = full_r;
   assign count    = count_r;
   assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_pf_issue_queue.sv
// Directed bench for pf_issue_queue: a queue model predicts issue order, occupancy and drops.
module tb_pf_issue_queue;

   localparam int DEPTH = 8;

   logic        clk;
   logic        rst;
   logic        pf_v;
   logic [15:0] pf_addr;
   logic        mem_v;
   logic [15:0] mem_addr;
   logic        mem_ready;
   logic        full;
   logic [3:0]  count;
   logic [15:0] drop_cnt;

   int          tests;
   int          fails;
   logic [15:0] exp_q[$];
   int          drops;

   pf_issue_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .pf_v      (pf_v),
      .pf_addr   (pf_addr),
      .mem_v     (mem_v),
      .mem_addr  (mem_addr),
      .mem_ready (mem_ready),
      .full      (full),
      .count     (count),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check/pop before the edge, model the edge, check state after it.
   task automatic cyc(input logic r, input logic v, input logic [15:0] a, input logic rdy);
      logic dup;
      logic is_full;
      rst = r; pf_v = v; pf_addr = a; mem_ready = rdy;
      #1;
      dup = 1'b0;
`ifdef PF_DEDUP_EN
      foreach (exp_q[i]) if (exp_q[i] == a) dup = 1'b1;
`endif
      is_full = (exp_q.size() == DEPTH);
      if (!r) begin
         chk("mem_v", {31'd0, mem_v}, {31'd0, exp_q.size() != 0});
         if (mem_v && rdy && exp_q.size() > 0) begin
            chk("issue_addr", {16'd0, mem_addr}, {16'd0, exp_q.pop_front()});
         end
         if (v) begin
            if (is_full || dup) begin
               if (drops < 65535) drops++;
            end else begin
               exp_q.push_back(a);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (r) begin
         exp_q.delete();
         drops = 0;
      end
      chk("count", {28'd0, count}, exp_q.size());
      chk("full", {31'd0, full}, {31'd0, exp_q.size() == DEPTH});
      chk("drop_cnt", {16'd0, drop_cnt}, drops);
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH + 2; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b1);
   endtask

   initial begin
      tests = 0; fails = 0; drops = 0;
      rst = 1'b1; pf_v = 1'b0; pf_addr = 16'h0000; mem_ready = 1'b0;
      @(negedge clk);
      cyc(1'b1, 1'b0, 16'h0000, 1'b0);
      cyc(1'b1, 1'b1, 16'h1234, 1'b1);
      chk("reset_mem_v", {31'd0, mem_v}, 32'd0);

      // Single push at cycle 10, issued next cycle and popped immediately.
      for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b1);
      cyc(1'b0, 1'b1, 16'h0010, 1'b1);
      chk("lat_mem_addr", {16'd0, mem_addr}, 32'h0010);
      cyc(1'b0, 1'b0, 16'h0000, 1'b1);
      chk("lat_empty", {28'd0, count}, 32'd0);

      // Fill to full, overflow drop, drop while popping, then ordered drain.
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 16'h0010 + 16'(i), 1'b0);
      cyc(1'b0, 1'b1, 16'h0018, 1'b0);
      chk("full_flag", {31'd0, full}, 32'd1);
      chk("full_drop", {16'd0, drop_cnt}, 32'd1);
      cyc(1'b0, 1'b1, 16'h0019, 1'b0);
      cyc(1'b0, 1'b1, 16'h001A, 1'b1);
      chk("full_pop_drop", {16'd0, drop_cnt}, 32'd3);
      drain();

      // Push with simultaneous pop on three entries.
      cyc(1'b1, 1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'h0030 + 16'(i), 1'b0);
      cyc(1'b0, 1'b1, 16'h0020, 1'b1);
      chk("pushpop_count", {28'd0, count}, 32'd3);
      drain();

      // Eleven pushes with ready toggling: pointers wrap.
      for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, 16'h0100 + 16'(i), 1'(i % 2));
      drain();

      // Duplicate addresses.
      cyc(1'b1, 1'b0, 16'h0000, 1'b0);
      cyc(1'b0, 1'b1, 16'h0011, 1'b0);
      cyc(1'b0, 1'b1, 16'h0011, 1'b0);
      cyc(1'b0, 1'b1, 16'h0012, 1'b0);
`ifdef PF_DEDUP_EN
      chk("dedup_count", {28'd0, count}, 32'd2);
      chk("dedup_drop", {16'd0, drop_cnt}, 32'd1);
`else
      chk("dup_count", {28'd0, count}, 32'd3);
      chk("dup_drop", {16'd0, drop_cnt}, 32'd0);
`endif
      drain();

      // Reset with five entries queued and push/pop requested.
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 16'h0200 + 16'(i), 1'b0);
      chk("pre_reset_mem_v", {31'd0, mem_v}, 32'd1);
      cyc(1'b1, 1'b1, 16'h0300, 1'b1);
      chk("post_reset_mem_v", {31'd0, mem_v}, 32'd0);
      chk("post_reset_count", {28'd0, count}, 32'd0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b1);

      // Drop counter saturation.
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 16'h0400 + 16'(i), 1'b0);
      for (int i = 0; i < 65540; i++) cyc(1'b0, 1'b1, 16'h0500, 1'b0);
      chk("drop_saturate", {16'd0, drop_cnt}, 32'h0000FFFF);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pf_issue_queue.md
PF_ISSUE_QUEUE -- requirements
Module: pf_issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, power of two, number of queued prefetch entries.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pf_v  input  1  prefetch request valid from the ISB prefetch output.
REQ-005 pf_addr  input  16  prefetch target address; sampled only when pf_v=1.
REQ-006 mem_v  output  1  issue request valid toward memory.
REQ-007 mem_addr  output  16  address being issued; meaningful only when mem_v=1.
REQ-008 mem_ready  input  1  memory accepts the issue request this cycle.
REQ-009 full  output  1  queue holds DEPTH entries.
REQ-010 count  output  log2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-011 drop_cnt  output  16  number of dropped prefetch requests, saturating.

Function
REQ-012 Storage shall be a circular FIFO with log2(DEPTH)-bit head and tail pointers that wrap from DEPTH-1 to 0.
REQ-013 Push: when pf_v=1, full=0 and the request is not dropped, pf_addr shall be written at tail, and tail shall increment at that edge.
REQ-014 Pop: when mem_v=1 and mem_ready=1 at a posedge, the head entry shall be removed, and head shall increment.
REQ-015 The control FSM shall have two states: EMPTY (mem_v=0) and ISSUE (mem_v=1, mem_addr=entry at head).
REQ-016 EMPTY->ISSUE on a push; ISSUE->EMPTY on a pop with count=1 and no push in the same cycle; otherwise the FSM holds state.
REQ-017 Latency: a push into an empty queue at edge N shall give mem_v=1 with that address during cycle N+1.
REQ-018 While mem_v=1 and mem_ready=0, mem_addr shall remain stable.
REQ-019 Simultaneous push and pop with 0<count<DEPTH: both occur and count is unchanged.
REQ-020 Full: pf_v=1 with full=1 shall drop the request, even if a pop occurs in the same cycle; drop_cnt increments.
REQ-021 drop_cnt shall saturate at 16'hFFFF.
REQ-022 count and full shall be registered and updated at the same edge as the push or pop.
REQ-023 mem_ready while mem_v=0 shall have no effect.

Reset
REQ-024 While rst=1 at a posedge: head=0, tail=0, count=0, full=0, FSM=EMPTY, mem_v=0, drop_cnt=0.
REQ-025 Reset shall take priority over a simultaneous push or pop, and queued entries shall be discarded with no issue.
REQ-026 mem_addr value after reset is don't-care; storage contents are not cleared.

Configuration
REQ-027 Macro PF_DEDUP_EN: when defined, a pf_v request whose pf_addr equals the address of any valid queued entry shall be dropped and counted in drop_cnt.
REQ-028 With PF_DEDUP_EN defined, an entry popped in the same cycle still counts as valid for the match.
REQ-029 With PF_DEDUP_EN defined, a full queue with a matching address shall increment drop_cnt by 1 only.
REQ-030 Without PF_DEDUP_EN, no address comparison logic shall exist and duplicates shall be queued normally.

Verification
REQ-031 Reset, then push 0x0010 at cycle 10 with mem_ready=1 -> mem_v=1, mem_addr=0x0010 in cycle 11; popped at edge 11; count returns to 0.
REQ-032 mem_ready=0; push 0x0010..0x0017 on consecutive cycles, then push 0x0018 -> full=1, count=8, drop_cnt=1; raising mem_ready issues 0x0010..0x0017 in order.
REQ-033 Queue holds 3 entries; push 0x0020 with mem_ready=1 in the same cycle -> count stays 3, and 0x0020 is issued fourth.
REQ-034 Push 11 entries with mem_ready toggling each cycle -> pointers wrap, and the issue order equals the push order with no loss.
REQ-035 With PF_DEDUP_EN defined: push 0x0011, 0x0011, 0x0012 with mem_ready=0 -> count=2, drop_cnt=1; without the macro -> count=3, drop_cnt=0.
REQ-036 Queue holds 5 entries and mem_v=1; assert rst for one cycle -> mem_v=0, count=0 and drop_cnt=0 in the next cycle, and no stale address is issued.
